// File: rtl/microwave_timer.sv
// -----------------------------------------------------------------------------
// microwave_timer
// Countdown timer core of the microwave controller. Keypad digits are shifted
// into a BCD mm:ss preset while idle. The preset then counts down one second
// per tick_1hz pulse while running with the door shut. The magnetron enable and
// the done indication are also generated here.
//
// Optional feature (compile-time macro QUICK_START_EN):
//   defined   - start at 0:00 in IDLE loads 0:30 and runs; start while running
//               adds 30 s, saturating at MAX_MIN:59.
//   undefined - start at 0:00 and start while running are ignored.
//
// Parameters:
//   MAX_MIN      largest minutes digit accepted (1..9)
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick_1hz     one-cycle pulse once per second
//   digit_valid  one-cycle pulse, digit_in holds a keypad digit
//   digit_in     keypad digit (BCD)
//   start        start / resume pulse
//   stop         pause pulse; cancels when paused or done
//   clear        abort pulse; zeroes the time
//   door_closed  level, 1 = door shut
//   min_out      BCD minutes
//   dseg_out     BCD tens of seconds
//   seg_out      BCD seconds
//   magnetron_on high only while running
//   done         high only when the count has expired
// -----------------------------------------------------------------------------
module microwave_timer #(
    parameter int unsigned MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] min_out,
    output logic [3:0] dseg_out,
    output logic [3:0] seg_out,
    output logic       magnetron_on,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MIN_D = 4'(MAX_MIN);

    state_t     state_r, state_nxt_s;
    logic [3:0] min_r, dseg_r, seg_r;
    logic [3:0] min_nxt_s, dseg_nxt_s, seg_nxt_s;
    logic       magnetron_r, done_r;
    logic       magnetron_nxt_s, done_nxt_s;
    logic [11:0] cd_s;
    logic       cd_zero_s;
    logic       time_zero_s;
    logic       entry_ok_s;

    // One-second BCD decrement of m:ds with both borrow wraps.
    function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] d,
                                            input logic [3:0] s);
        logic [11:0] r;
        if (s != 4'd0) begin
            r = {m, d, s - 4'd1};
        end else if (d != 4'd0) begin
            r = {m, d - 4'd1, 4'd9};
        end else if (m != 4'd0) begin
            r = {m - 4'd1, 4'd5, 4'd9};
        end else begin
            r = 12'h000;
        end
        return r;
    endfunction

    // BCD add of 30 s, carrying into minutes and saturating at MAX_MIN:59.
    function automatic logic [11:0] bcd_add30(input logic [3:0] m, input logic [3:0] d,
                                              input logic [3:0] s);
        logic [11:0] r;
        if (d <= 4'd2) begin
            r = {m, d + 4'd3, s};
        end else if (m < MAX_MIN_D) begin
            r = {m + 4'd1, d - 4'd3, s};
        end else begin
            r = {MAX_MIN_D, 4'd5, 4'd9};
        end
        return r;
    endfunction

    assign cd_s        = bcd_dec(min_r, dseg_r, seg_r);
    assign cd_zero_s   = (cd_s == 12'h000);
    assign time_zero_s = (min_r == 4'd0) && (dseg_r == 4'd0) && (seg_r == 4'd0);
    // Shifting must keep dseg in 0..5 and min in 0..MAX_MIN.
    assign entry_ok_s  = (digit_in <= 4'd9) && (seg_r <= 4'd5) && (dseg_r <= MAX_MIN_D);

    // State and time digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            min_r   <= 4'd0;
            dseg_r  <= 4'd0;
            seg_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            min_r   <= min_nxt_s;
            dseg_r  <= dseg_nxt_s;
            seg_r   <= seg_nxt_s;
        end
    end

    // Next state and digits; commands ranked clear > stop > start > digit.
    always_comb begin
        state_nxt_s = state_r;
        min_nxt_s   = min_r;
        dseg_nxt_s  = dseg_r;
        seg_nxt_s   = seg_r;
        if (clear) begin
            state_nxt_s = ST_IDLE;
            min_nxt_s   = 4'd0;
            dseg_nxt_s  = 4'd0;
            seg_nxt_s   = 4'd0;
        end else if ((state_r == ST_RUNNING) && (stop || !door_closed)) begin
            // Pausing swallows any tick in the same cycle.
            state_nxt_s = ST_PAUSED;
        end else if (stop) begin
            case (state_r)
                ST_PAUSED, ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                    min_nxt_s   = 4'd0;
                    dseg_nxt_s  = 4'd0;
                    seg_nxt_s   = 4'd0;
                end
                default: state_nxt_s = state_r;
            endcase
        end else if (start) begin
            case (state_r)
                ST_IDLE: begin
                    if (!door_closed) begin
                        state_nxt_s = state_r;
                    end else if (!time_zero_s) begin
                        state_nxt_s = ST_RUNNING;
                    end else begin
`ifdef QUICK_START_EN
                        state_nxt_s = ST_RUNNING;
                        min_nxt_s   = 4'd0;
                        dseg_nxt_s  = 4'd3;
                        seg_nxt_s   = 4'd0;
`else
                        state_nxt_s = state_r;
`endif
                    end
                end
                ST_PAUSED: begin
                    if (door_closed) begin
                        state_nxt_s = ST_RUNNING;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RUNNING: begin
`ifdef QUICK_START_EN
                    {min_nxt_s, dseg_nxt_s, seg_nxt_s} = bcd_add30(min_r, dseg_r, seg_r);
`else
                    // start is not a command here, so the tick still counts.
                    if (tick_1hz) begin
                        {min_nxt_s, dseg_nxt_s, seg_nxt_s} = cd_s;
                        state_nxt_s = cd_zero_s ? ST_DONE : ST_RUNNING;
                    end else begin
                        state_nxt_s = state_r;
                    end
`endif
                end
                default: state_nxt_s = state_r;
            endcase
        end else if (digit_valid && (state_r == ST_IDLE)) begin
            if (entry_ok_s) begin
                min_nxt_s  = dseg_r;
                dseg_nxt_s = seg_r;
                seg_nxt_s  = digit_in;
            end else begin
                state_nxt_s = state_r;
            end
        end else if ((state_r == ST_RUNNING) && tick_1hz) begin
            {min_nxt_s, dseg_nxt_s, seg_nxt_s} = cd_s;
            state_nxt_s = cd_zero_s ? ST_DONE : ST_RUNNING;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output decode from the next state so the flags change on the same edge.
    always_comb begin
        magnetron_nxt_s = (state_nxt_s == ST_RUNNING) && door_closed;
        done_nxt_s      = (state_nxt_s == ST_DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            magnetron_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            magnetron_r <= magnetron_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign min_out      = min_r;
    assign dseg_out     = dseg_r;
    assign seg_out      = seg_r;
    assign magnetron_on = magnetron_r;
    assign done         = done_r;

endmodule

// File: tb/tb_microwave_timer.sv
// -----------------------------------------------------------------------------
// tb_microwave_timer
// Self-checking bench for microwave_timer. A reference model tracks the time
// as a plain number of seconds plus a symbolic mode, and is compared against
// the DUT after every clock edge. Directed scenarios are followed by a
// randomized command stream. Honours QUICK_START_EN like the design.
// -----------------------------------------------------------------------------
module tb_microwave_timer;

    localparam int MAX_MIN = 9;
    localparam int MAXT    = MAX_MIN * 60 + 59;
`ifdef QUICK_START_EN
    localparam bit QS = 1'b1;
`else
    localparam bit QS = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, digit_valid, start, stop, clear, door_closed;
    logic [3:0] digit_in;
    logic [3:0] min_out, dseg_out, seg_out;
    logic       magnetron_on, done;

    int total = 0;
    int bad   = 0;
    int m_tot = 0;
    int m_st  = M_IDLE;

    microwave_timer #(.MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .digit_valid(digit_valid),
        .digit_in(digit_in), .start(start), .stop(stop), .clear(clear),
        .door_closed(door_closed), .min_out(min_out), .dseg_out(dseg_out),
        .seg_out(seg_out), .magnetron_on(magnetron_on), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_digits();
        int m, t, s;
        logic [11:0] r;
        m = m_tot / 60;
        t = (m_tot % 60) / 10;
        s = m_tot % 10;
        r = {m[3:0], t[3:0], s[3:0]};
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_dig"}, {min_out, dseg_out, seg_out}, exp_digits());
        check({tag, "_mag"}, {11'd0, magnetron_on}, {11'd0, (m_st == M_RUN)});
        check({tag, "_done"}, {11'd0, done}, {11'd0, (m_st == M_DONE)});
    endtask

    task automatic model_tick();
        m_tot = m_tot - 1;
        if (m_tot == 0) m_st = M_DONE;
    endtask

    // Reference behaviour for one clock edge, from the command rules.
    task automatic model_step(input logic dv, input logic [3:0] di, input logic st,
                              input logic sp, input logic cl, input logic dc, input logic tk);
        int t, s;
        t = (m_tot % 60) / 10;
        s = m_tot % 10;
        if (cl) begin
            m_st = M_IDLE; m_tot = 0;
        end else if (m_st == M_RUN && (sp || !dc)) begin
            m_st = M_PAUSE;
        end else if (sp) begin
            if (m_st == M_PAUSE || m_st == M_DONE) begin
                m_st = M_IDLE; m_tot = 0;
            end
        end else if (st) begin
            if (dc && m_st == M_IDLE && m_tot > 0) m_st = M_RUN;
            else if (dc && m_st == M_IDLE && QS) begin m_tot = 30; m_st = M_RUN; end
            else if (dc && m_st == M_PAUSE) m_st = M_RUN;
            else if (m_st == M_RUN && QS) m_tot = (m_tot + 30 > MAXT) ? MAXT : m_tot + 30;
            else if (m_st == M_RUN && tk) model_tick();
        end else if (dv && m_st == M_IDLE) begin
            if (di <= 4'd9 && s <= 5 && t <= MAX_MIN) m_tot = t * 60 + s * 10 + int'(di);
        end else if (m_st == M_RUN && tk) begin
            model_tick();
        end
    endtask

    task automatic step(input string tag, input logic dv, input logic [3:0] di,
                        input logic st, input logic sp, input logic cl,
                        input logic dc, input logic tk);
        @(negedge clk);
        digit_valid = dv; digit_in = di; start = st; stop = sp;
        clear = cl; door_closed = dc; tick_1hz = tk;
        @(posedge clk);
        model_step(dv, di, st, sp, cl, dc, tk);
        #1;
        check_all(tag);
        digit_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        step("key", 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic go();   step("start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic halt(); step("stop",  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); endtask
    task automatic clr();  step("clear", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); endtask
    task automatic tick(); step("tick",  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk); rst_n = 1'b1;

        // Asynchronous reset while cooking at 1:23.
        key(4'd1); key(4'd2); key(4'd3);
        go();
        check("run_123", {min_out, dseg_out, seg_out}, 12'h123);
        step("idle_run", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2; rst_n = 1'b0; #1;
        m_tot = 0; m_st = M_IDLE;
        check_all("async_rst");
        @(posedge clk); @(negedge clk); rst_n = 1'b1;

        // 1:30 then three ticks.
        key(4'd1); key(4'd3); key(4'd0);
        check("preset_130", {min_out, dseg_out, seg_out}, 12'h130);
        go();
        check("mag_after_start", {11'd0, magnetron_on}, 12'd1);
        tick(); check("t_129", {min_out, dseg_out, seg_out}, 12'h129);
        tick(); check("t_128", {min_out, dseg_out, seg_out}, 12'h128);
        tick(); check("t_127", {min_out, dseg_out, seg_out}, 12'h127);
        clr();

        // Expiry from 0:02.
        key(4'd2); go(); tick();
        check("t_001", {min_out, dseg_out, seg_out}, 12'h001);
        tick();
        check("expire_done", {11'd0, done}, 12'd1);
        check("expire_mag", {11'd0, magnetron_on}, 12'd0);
        go();
        check("done_start_ign", {11'd0, done}, 12'd1);
        halt();
        check("done_stop", {11'd0, done}, 12'd0);

        // Double borrow and digit rejection.
        key(4'd1); key(4'd0); key(4'd0); go(); tick();
        check("borrow_059", {min_out, dseg_out, seg_out}, 12'h059);
        clr();
        key(4'd9); key(4'd9); key(4'd5);
        check("reject_009", {min_out, dseg_out, seg_out}, 12'h009);
        clr();
        key(4'hA);
        check("reject_gt9", {min_out, dseg_out, seg_out}, 12'h000);

        // Door opens with a tick at 0:45, resume, stop twice.
        key(4'd4); key(4'd5); go();
        step("door_open", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("door_045", {min_out, dseg_out, seg_out}, 12'h045);
        go();
        check("resume_mag", {11'd0, magnetron_on}, 12'd1);
        halt(); halt();
        check("stop2_zero", {min_out, dseg_out, seg_out}, 12'h000);

        // clear beats start.
        key(4'd2); key(4'd1); key(4'd0); go();
        step("clr_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_wins", {min_out, dseg_out, seg_out}, 12'h000);

`ifdef QUICK_START_EN
        go();
        check("qs_030", {min_out, dseg_out, seg_out}, 12'h030);
        clr();
        key(4'd9); key(4'd4); key(4'd5); go(); go();
        check("qs_sat", {min_out, dseg_out, seg_out}, 12'h959);
        clr();
`else
        go();
        check("zero_start_mag", {11'd0, magnetron_on}, 12'd0);
`endif

        // Randomized command stream against the model.
        for (int i = 0; i < 600; i++) begin
            logic dv, st, sp, cl, dc, tk;
            logic [3:0] di;
            dv = ($urandom_range(0, 99) < 30);
            di = 4'($urandom_range(0, 11));
            st = ($urandom_range(0, 99) < 10);
            sp = ($urandom_range(0, 99) < 4);
            cl = ($urandom_range(0, 99) < 2);
            dc = ($urandom_range(0, 99) < 92);
            tk = ($urandom_range(0, 99) < 35);
            step("rand", dv, di, st, sp, cl, dc, tk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
